router_pe_port: RTL and testbench
=================================

# router_pe_port

Router-side endpoint of the PE/NIC link protocol: the local port each mesh router presents to its `nic_pe_module`. It accepts packets the NIC sends (`pesi`/`pedi`, gated by `peri`) into per-virtual-channel injection buffers and hands them to the router crossbar. It also buffers packets the crossbar ejects and delivers them to the NIC (`peso`/`pedo`, gated by `pero`). Even/odd virtual channels alternate between the external link and the internal pipeline under the global `polarity` signal.

## Interface
Parameters:
- DATA_WIDTH, 64, packet width; bit DATA_WIDTH-1 is the VC bit (0 = even, 1 = odd).
- CNT_WIDTH, 16, width of the packet counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- polarity  in  1  global phase. During phase p, the NIC link transfers VC p and the internal side transfers VC ~p.
- pesi  in  1  NIC send strobe.
- pedi  in  DATA_WIDTH  NIC packet.
- peri  out  1  ready to NIC: the injection buffer for VC `polarity` is empty.
- peso  out  1  send strobe to NIC; registered.
- pedo  out  DATA_WIDTH  packet to NIC; registered.
- pero  in  1  NIC ready to accept.
- inj_valid  out  1  injection packet available for VC ~polarity.
- inj_data  out  DATA_WIDTH  that packet.
- inj_grant  in  1  crossbar consumed inj_data this cycle.
- ej_valid  in  1  crossbar delivering an ejected packet of VC ~polarity.
- ej_data  in  DATA_WIDTH  ejected packet.
- ej_ready  out  1  ejection buffer for VC ~polarity is empty.
- vc_err  out  1  sticky flag: NIC sent a packet whose VC bit ≠ polarity.
- inj_count  out  CNT_WIDTH  packets accepted from the NIC.
- ej_count  out  CNT_WIDTH  packets delivered to the NIC.

## Operation
- State: inj_buf[2] and ej_buf[2], each one entry with a full bit. Also the peso/pedo registers, vc_err, and the two counters.
- NIC injection (VC v = polarity):
  - Accept when `pesi && peri && pedi[DATA_WIDTH-1]==v`. Write inj_buf[v], set it full, increment inj_count.
  - `pesi` while `peri`=0 is ignored (NIC protocol violation; no state change).
  - VC mismatch: the packet is dropped, vc_err is set, and inj_count does not increment.
- Crossbar injection (VC u = ~polarity):
  - inj_valid = inj_full[u]; inj_data = inj_buf[u] (combinational).
  - inj_grant while inj_valid clears inj_full[u]. inj_grant while inj_valid=0 is ignored.
- Crossbar ejection (VC u):
  - ej_ready = ~ej_full[u].
  - ej_valid && ej_ready writes ej_buf[u] and sets it full. ej_valid while full is ignored; the router must not do this.
- NIC delivery (VC v):
  - If ej_full[v] && pero: next cycle peso=1, pedo=ej_buf[v]. ej_full[v] clears and ej_count increments.
  - Otherwise peso=0 next cycle and pedo holds its last value.
- Because the NIC side and the crossbar side always address opposite VCs, no buffer is ever filled and drained in the same cycle. Each of the four buffers has at most one writer or reader per cycle.
- Counters wrap modulo 2^CNT_WIDTH. vc_err clears only on reset.

## Timing
- Reset: every full bit = 0, so peri=1, ej_ready=1, inj_valid=0. Also peso=0, pedo=0, vc_err=0, counters=0. Reset mid-operation discards all buffered packets immediately (asynchronous).
- peri, inj_valid, inj_data and ej_ready are combinational from registered state and `polarity` only. They do not depend on same-cycle pesi, inj_grant or ej_valid.
- Latency:
  - NIC accept to inj_valid: the first cycle with polarity flipped (≥1 cycle).
  - Ejection write to peso: ≥2 cycles. The write happens in phase ~v, then phase v with pero gives a registered peso.
- peso is a single-cycle pulse per packet; back-to-back pulses are possible on alternate cycles (alternating VCs).
- Full buffer on the NIC side: peri=0 until the crossbar drains it in an opposite-phase cycle.
- pero low: the ej buffer holds, and ej_ready for that VC stays 0 in later opposite phases.

## Structure
- Shared package (noc_pkg): VC_BIT index, VC_EVEN/VC_ODD constants, and the DATA_WIDTH default.
- One natural sub-module, `vc_slot`: a one-entry buffer (data register + full bit, write/clear inputs, async reset). It is instantiated four times. All remaining logic stays in the top.

## Test plan
- Reset, polarity toggling each cycle → peri=1, ej_ready=1, inj_valid=0, peso=0, counters=0.
- polarity=0, pesi=1, pedi=0x0000_0000_0000_00A5; next cycle (polarity=1) → inj_valid=1 with inj_data=0x…A5. inj_grant=1 → inj_valid drops the following cycle; inj_count=1.
- polarity=1, pesi with VC bit=0 → packet dropped; vc_err=1 and stays 1; inj_count unchanged.
- Fill inj_buf[0], withhold inj_grant for 6 cycles → peri=0 in every polarity=0 cycle. A further pesi in those cycles changes nothing.
- polarity=0, ej_valid=1, ej_data=0x8000_0000_0000_1234 (odd VC); pero=1 → peso=1 for exactly one cycle with pedo=0x8000_0000_0000_1234, two cycles after the write; ej_count=1.
- Same as the previous scenario but pero=0 for 4 cycles → peso stays 0 and ej_ready=0 in polarity=0 cycles. Raise pero → one peso pulse. Then assert reset mid-stream → all outputs return to their reset values on the same cycle.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet width default and virtual-channel encoding.
package noc_pkg;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int VC_BIT         = DATA_WIDTH_DEF - 1;
  localparam logic VC_EVEN      = 1'b0;
  localparam logic VC_ODD       = 1'b1;
  localparam int NUM_VC         = 2;
endpackage

// File: rtl/router_pe_port_vc_slot.sv
// One-entry packet buffer: data register plus full flag.
module vc_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         clr,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic [W-1:0] data
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (wr)       full <= 1'b1;
      else if (clr) full <= 1'b0;
      if (wr)       data <= wdata;
    end
  end
endmodule

// File: rtl/router_pe_port.sv
// Router local port toward the NIC: per-VC injection/ejection slots whose
// even/odd roles swap each polarity phase between the NIC link and crossbar.
module router_pe_port
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  polarity,
  input  logic                  pesi,
  input  logic [DATA_WIDTH-1:0] pedi,
  output logic                  peri,
  output logic                  peso,
  output logic [DATA_WIDTH-1:0] pedo,
  input  logic                  pero,
  output logic                  inj_valid,
  output logic [DATA_WIDTH-1:0] inj_data,
  input  logic                  inj_grant,
  input  logic                  ej_valid,
  input  logic [DATA_WIDTH-1:0] ej_data,
  output logic                  ej_ready,
  output logic                  vc_err,
  output logic [CNT_WIDTH-1:0]  inj_count,
  output logic [CNT_WIDTH-1:0]  ej_count
);
  logic link_vc, core_vc;
  logic [NUM_VC-1:0] inj_full, ej_full;
  logic [NUM_VC-1:0] inj_wr, inj_clr, ej_wr, ej_clr;
  logic [NUM_VC-1:0][DATA_WIDTH-1:0] inj_buf, ej_buf;
  logic take, accept, bad_vc, inj_pop, ej_push, deliver;

  assign link_vc = polarity;
  assign core_vc = ~polarity;

  assign peri      = ~inj_full[link_vc];
  assign inj_valid = inj_full[core_vc];
  assign inj_data  = inj_buf[core_vc];
  assign ej_ready  = ~ej_full[core_vc];

  // A send while not ready is dropped silently, even with a bad VC bit.
  assign take    = pesi && peri;
  assign accept  = take && (pedi[DATA_WIDTH-1] == link_vc);
  assign bad_vc  = take && (pedi[DATA_WIDTH-1] != link_vc);
  assign inj_pop = inj_grant && inj_full[core_vc];
  assign ej_push = ej_valid && ~ej_full[core_vc];
  assign deliver = pero && ej_full[link_vc];

  always_comb begin
    inj_wr  = '0;
    inj_clr = '0;
    ej_wr   = '0;
    ej_clr  = '0;
    inj_wr[link_vc]  = accept;
    inj_clr[core_vc] = inj_pop;
    ej_wr[core_vc]   = ej_push;
    ej_clr[link_vc]  = deliver;
  end

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    vc_slot #(.W(DATA_WIDTH)) u_inj (
      .clk(clk), .reset(reset), .wr(inj_wr[i]), .clr(inj_clr[i]),
      .wdata(pedi), .full(inj_full[i]), .data(inj_buf[i])
    );
    vc_slot #(.W(DATA_WIDTH)) u_ej (
      .clk(clk), .reset(reset), .wr(ej_wr[i]), .clr(ej_clr[i]),
      .wdata(ej_data), .full(ej_full[i]), .data(ej_buf[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peso      <= 1'b0;
      pedo      <= '0;
      vc_err    <= 1'b0;
      inj_count <= '0;
      ej_count  <= '0;
    end else begin
      peso <= deliver;
      if (deliver) begin
        pedo     <= ej_buf[link_vc];
        ej_count <= ej_count + 1'b1;
      end
      if (accept) inj_count <= inj_count + 1'b1;
      if (bad_vc) vc_err    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_router_pe_port.sv
// Scoreboard bench for router_pe_port: queue-based model of the four slots.
module tb_router_pe_port;
  import noc_pkg::*;
  localparam int DW = 64;
  localparam int CW = 16;

  logic clk = 1'b0, reset = 1'b1, polarity = 1'b0;
  logic pesi = 1'b0, pero = 1'b0, inj_grant = 1'b0, ej_valid = 1'b0;
  logic [DW-1:0] pedi = '0, ej_data = '0;
  logic peri, peso, inj_valid, ej_ready, vc_err;
  logic [DW-1:0] pedo, inj_data;
  logic [CW-1:0] inj_count, ej_count;

  router_pe_port #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .pesi(pesi), .pedi(pedi), .peri(peri),
    .peso(peso), .pedo(pedo), .pero(pero),
    .inj_valid(inj_valid), .inj_data(inj_data), .inj_grant(inj_grant),
    .ej_valid(ej_valid), .ej_data(ej_data), .ej_ready(ej_ready),
    .vc_err(vc_err), .inj_count(inj_count), .ej_count(ej_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit run = 1'b0;

  // Reference model: each VC slot is a queue holding 0 or 1 packets.
  logic [DW-1:0] inj_m0[$], inj_m1[$], ej_m0[$], ej_m1[$], peso_exp[$];
  logic [CW-1:0] m_inj_cnt = '0, m_ej_cnt = '0;
  logic          m_err = 1'b0;
  logic [DW-1:0] m_pedo = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int inj_size(input logic vc);
    return vc ? inj_m1.size() : inj_m0.size();
  endfunction
  function automatic int ej_size(input logic vc);
    return vc ? ej_m1.size() : ej_m0.size();
  endfunction

  task automatic model_clear();
    inj_m0.delete(); inj_m1.delete(); ej_m0.delete(); ej_m1.delete();
    peso_exp.delete();
    m_inj_cnt = '0; m_ej_cnt = '0; m_err = 1'b0; m_pedo = '0;
  endtask

  // Combinational checks, then advance the model for the coming edge.
  always @(negedge clk) begin
    #2;
    if (run && !reset) begin
      logic v, u;
      v = polarity; u = ~polarity;
      chk("peri", peri, inj_size(v) == 0);
      chk("inj_valid", inj_valid, inj_size(u) != 0);
      if (inj_size(u) != 0) chk("inj_data", inj_data, u ? inj_m1[0] : inj_m0[0]);
      chk("ej_ready", ej_ready, ej_size(u) == 0);
      if (pesi && inj_size(v) == 0) begin
        if (pedi[VC_BIT] == v) begin
          if (v) inj_m1.push_back(pedi); else inj_m0.push_back(pedi);
          m_inj_cnt++;
        end else m_err = 1'b1;
      end
      if (inj_grant && inj_size(u) != 0) begin
        if (u) void'(inj_m1.pop_front()); else void'(inj_m0.pop_front());
      end
      if (ej_valid && ej_size(u) == 0) begin
        if (u) ej_m1.push_back(ej_data); else ej_m0.push_back(ej_data);
      end
      if (pero && ej_size(v) != 0) begin
        peso_exp.push_back(v ? ej_m1.pop_front() : ej_m0.pop_front());
        m_ej_cnt++;
      end
    end
  end

  // Registered outputs just after each edge.
  always @(posedge clk) begin
    #1;
    if (run && !reset) begin
      if (peso_exp.size() > 0) begin
        m_pedo = peso_exp.pop_front();
        chk("peso", peso, 1);
        chk("pedo", pedo, m_pedo);
      end else begin
        chk("peso", peso, 0);
        chk("pedo_hold", pedo, m_pedo);
      end
      chk("vc_err", vc_err, m_err);
      chk("inj_count", inj_count, m_inj_cnt);
      chk("ej_count", ej_count, m_ej_cnt);
    end
  end

  task automatic drive(input logic pol, input logic si, input logic [DW-1:0] di,
                       input logic gnt, input logic ev, input logic [DW-1:0] ed,
                       input logic ro);
    @(negedge clk);
    polarity = pol; pesi = si; pedi = di; inj_grant = gnt;
    ej_valid = ev; ej_data = ed; pero = ro;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_peri"}, peri, 1);
    chk({tag, "_ej_ready"}, ej_ready, 1);
    chk({tag, "_inj_valid"}, inj_valid, 0);
    chk({tag, "_peso"}, peso, 0);
    chk({tag, "_pedo"}, pedo, 0);
    chk({tag, "_vc_err"}, vc_err, 0);
    chk({tag, "_inj_count"}, inj_count, 0);
    chk({tag, "_ej_count"}, ej_count, 0);
  endtask

  initial begin
    logic [DW-1:0] pkt;
    logic p;
    // Held in reset with polarity toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); polarity = ~polarity;
      #2; check_reset_outputs("rst");
    end
    @(negedge clk); reset = 1'b0; polarity = 1'b0; run = 1'b1;

    // Even-VC packet from NIC, granted in the following odd phase.
    drive(0, 1, 64'h0000_0000_0000_00A5, 0, 0, '0, 0);
    drive(1, 0, '0, 1, 0, '0, 0);
    drive(0, 0, '0, 0, 0, '0, 0);
    drive(1, 0, '0, 0, 0, '0, 0);

    // VC mismatch in odd phase: dropped and flagged.
    drive(1, 1, 64'h0000_0000_0000_0055, 0, 0, '0, 0);
    drive(0, 0, '0, 0, 0, '0, 0);
    drive(1, 0, '0, 0, 0, '0, 0);

    // Fill inj_buf[0], withhold grant; extra sends must be ignored.
    drive(0, 1, 64'h0000_0000_0000_0111, 0, 0, '0, 0);
    for (int i = 0; i < 6; i++)
      drive(i[0] ? 1'b0 : 1'b1, i[0], 64'h0000_0000_0000_0222, 0, 0, '0, 0);
    drive(1, 0, '0, 1, 0, '0, 0);
    drive(0, 0, '0, 0, 0, '0, 0);

    // Odd-VC ejection delivered with pero high.
    drive(0, 0, '0, 0, 1, 64'h8000_0000_0000_1234, 1);
    drive(1, 0, '0, 0, 0, '0, 1);
    drive(0, 0, '0, 0, 0, '0, 1);
    drive(1, 0, '0, 0, 0, '0, 0);

    // Same with pero withheld, then released, then reset mid-stream.
    drive(0, 0, '0, 0, 1, 64'h8000_0000_0000_5678, 0);
    for (int i = 0; i < 4; i++)
      drive(i[0] ? 1'b0 : 1'b1, 0, '0, 0, i[0], 64'h8000_0000_0000_9999, 0);
    drive(1, 0, '0, 0, 0, '0, 1);
    drive(0, 1, 64'h0000_0000_0000_0777, 0, 1, 64'h8000_0000_0000_4321, 0);
    drive(1, 1, 64'h8000_0000_0000_0888, 0, 1, 64'h0000_0000_0000_4444, 1);
    drive(0, 0, '0, 0, 0, '0, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1; check_reset_outputs("midrst");
    model_clear();
    @(negedge clk); reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      p = ($urandom_range(0, 9) < 8) ? ~polarity : polarity;
      pkt = {$urandom, $urandom};
      pkt[VC_BIT] = ($urandom_range(0, 19) == 0) ? ~p : p;
      drive(p, $urandom_range(0, 1), pkt, $urandom_range(0, 1),
            $urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 9) < 7);
    end
    drive(0, 0, '0, 0, 0, '0, 0);
    drive(1, 0, '0, 0, 0, '0, 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
